// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports, the status flag and the data-RAM bus seen by mem_arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [3:0]  p0_be;
  logic [13:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_ack;
  logic [31:0] p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [3:0]  p1_be;
  logic [13:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_ack;
  logic [31:0] p1_rdata;

  logic        busy;

  logic        ram_we;
  logic        ram_re;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  p0_req, p0_we, p0_be, p0_addr, p0_wdata,
    output p0_ack, p0_rdata,
    input  p1_req, p1_we, p1_be, p1_addr, p1_wdata,
    output p1_ack, p1_rdata,
    output busy,
    output ram_we, ram_re, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output p0_req, p0_we, p0_be, p0_addr, p0_wdata,
    input  p0_ack, p0_rdata,
    output p1_req, p1_we, p1_be, p1_addr, p1_wdata,
    input  p1_ack, p1_rdata,
    input  busy,
    input  ram_we, ram_re, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port word RAM; partial writes are done as
// read-modify-write so the RAM only ever sees full-word write strobes.
module mem_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;

  logic        lat_port;
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [13:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rbuf;
  logic        last_grant;
  logic [31:0] p0_rdata_q;
  logic [31:0] p1_rdata_q;

  logic        any_req;
  logic        grant_port;
  logic        full_write;
  logic        partial_write;

  logic        ram_we_c;
  logic        ram_re_c;
  logic [31:0] ram_wdata_c;
  logic        busy_c;
  logic        p0_ack_c;
  logic        p1_ack_c;

  function automatic logic [31:0] merge_bytes(input logic [31:0] new_word,
                                               input logic [31:0] old_word,
                                               input logic [3:0]  be);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        result[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return result;
  endfunction

  assign any_req       = bus.p0_req | bus.p1_req;
  assign full_write    = lat_we && (lat_be == 4'b1111);
  assign partial_write = lat_we && (lat_be != 4'b0000) && (lat_be != 4'b1111);

  // Winner selection; only consulted in IDLE when some port is requesting.
  always_comb begin
    grant_port = 1'b0;
    if (FIXED_PRIO != 0) begin
      grant_port = !bus.p0_req;
    end else if (bus.p0_req && bus.p1_req) begin
      grant_port = !last_grant;
    end else begin
      grant_port = !bus.p0_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Strobes and acks are masked by reset so an aborted RMW never reaches the RAM.
  always_comb begin
    next_state  = state;
    ram_we_c    = 1'b0;
    ram_re_c    = 1'b0;
    ram_wdata_c = 32'h0;
    busy_c      = 1'b0;
    p0_ack_c    = 1'b0;
    p1_ack_c    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        busy_c   = 1'b1;
        ram_re_c = 1'b1;
        if (full_write) begin
          ram_we_c    = 1'b1;
          ram_wdata_c = lat_wdata;
        end
        next_state = partial_write ? WRITE : RESP;
      end
      WRITE: begin
        busy_c      = 1'b1;
        ram_we_c    = 1'b1;
        ram_wdata_c = merge_bytes(lat_wdata, rbuf, lat_be);
        next_state  = RESP;
      end
      RESP: begin
        busy_c     = 1'b1;
        p0_ack_c   = !lat_port;
        p1_ack_c   = lat_port;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (reset) begin
      ram_we_c    = 1'b0;
      ram_re_c    = 1'b0;
      ram_wdata_c = 32'h0;
      busy_c      = 1'b0;
      p0_ack_c    = 1'b0;
      p1_ack_c    = 1'b0;
    end
  end

  // Request latch, grant pointer and read buffers.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_port   <= 1'b0;
      lat_we     <= 1'b0;
      lat_be     <= 4'h0;
      lat_addr   <= 14'h0;
      lat_wdata  <= 32'h0;
      rbuf       <= 32'h0;
      last_grant <= 1'b1;
      p0_rdata_q <= 32'h0;
      p1_rdata_q <= 32'h0;
    end else begin
      if (state == IDLE && any_req) begin
        lat_port   <= grant_port;
        last_grant <= grant_port;
        if (grant_port) begin
          lat_we    <= bus.p1_we;
          lat_be    <= bus.p1_be;
          lat_addr  <= bus.p1_addr;
          lat_wdata <= bus.p1_wdata;
        end else begin
          lat_we    <= bus.p0_we;
          lat_be    <= bus.p0_be;
          lat_addr  <= bus.p0_addr;
          lat_wdata <= bus.p0_wdata;
        end
      end
      if (state == ACCESS) begin
        rbuf <= bus.ram_rdata;
        if (lat_port) begin
          p1_rdata_q <= bus.ram_rdata;
        end else begin
          p0_rdata_q <= bus.ram_rdata;
        end
      end
    end
  end

  assign bus.ram_we    = ram_we_c;
  assign bus.ram_re    = ram_re_c;
  assign bus.ram_addr  = lat_addr;
  assign bus.ram_wdata = ram_wdata_c;
  assign bus.busy      = busy_c;
  assign bus.p0_ack    = p0_ack_c;
  assign bus.p1_ack    = p1_ack_c;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance with a byte-lane RAM model and
// a fixed-priority instance with a read-only address-pattern RAM; acks checked against a queue.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic ram_init;

  always #5 clk = ~clk;

  mem_arbiter_if rr_if ();
  mem_arbiter_if fp_if ();

  mem_arbiter #(.FIXED_PRIO(0)) dut_rr (.clk(clk), .reset(reset), .bus(rr_if.slave));
  mem_arbiter #(.FIXED_PRIO(1)) dut_fp (.clk(clk), .reset(reset), .bus(fp_if.slave));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  // RAM for the round-robin instance: untouched words read back a fixed pattern.
  logic [31:0] mem     [0:4095];
  logic        written [0:4095];

  function automatic logic [31:0] init_word(input logic [11:0] w);
    return (w == 12'd4) ? 32'hAABBCCDD : {20'hC0DE0, w};
  endfunction

  assign rr_if.ram_rdata = !rr_if.ram_re ? 32'h0 :
                           (written[rr_if.ram_addr[13:2]] ? mem[rr_if.ram_addr[13:2]]
                                                          : init_word(rr_if.ram_addr[13:2]));

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 4096; i++) written[i] <= 1'b0;
    end else if (rr_if.ram_we) begin
      mem[rr_if.ram_addr[13:2]]     <= rr_if.ram_wdata;
      written[rr_if.ram_addr[13:2]] <= 1'b1;
    end
  end

  assign fp_if.ram_rdata = fp_if.ram_re ? (32'h5A5A0000 ^ {18'h0, fp_if.ram_addr}) : 32'h0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input logic port, input logic req, input logic we, input logic [3:0] be,
                          input logic [13:0] addr, input logic [31:0] wdata);
    if (port) begin
      rr_if.p1_req = req; rr_if.p1_we = we; rr_if.p1_be = be;
      rr_if.p1_addr = addr; rr_if.p1_wdata = wdata;
    end else begin
      rr_if.p0_req = req; rr_if.p0_we = we; rr_if.p0_be = be;
      rr_if.p0_addr = addr; rr_if.p0_wdata = wdata;
    end
  endtask

  // One lone transaction starting in IDLE; exp_we_cycle 0 means no RAM write expected.
  task automatic apply_stimulus(input logic port, input logic we, input logic [3:0] be,
                                input logic [13:0] addr, input logic [31:0] wdata,
                                input int exp_lat, input logic [31:0] exp_rdata,
                                input int exp_we_cycle, input logic [31:0] exp_wdata);
    int lat, we_cycle, we_count;
    logic [31:0] wd;
    exp_t e;
    lat = -1; we_cycle = 0; we_count = 0; wd = 32'h0;
    e.port = port; e.rdata = exp_rdata;
    sb.push_back(e);
    @(posedge clk); #1;
    set_port(port, 1'b1, we, be, addr, wdata);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rr_if.ram_we) begin
        we_count++; we_cycle = k; wd = rr_if.ram_wdata;
      end
      if (port ? rr_if.p1_ack : rr_if.p0_ack) begin
        lat = k;
        set_port(port, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        break;
      end
    end
    check_output("ack_latency", lat, exp_lat);
    check_output("we_count", we_count, (exp_we_cycle != 0) ? 1 : 0);
    if (exp_we_cycle != 0) begin
      check_output("we_cycle", we_cycle, exp_we_cycle);
      check_output("we_data", wd, exp_wdata);
    end
  endtask

  // Scoreboard and bus invariants on the round-robin instance.
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (rr_if.p0_ack || rr_if.p1_ack) begin
        check_output("ack_exclusive", {31'h0, rr_if.p0_ack & rr_if.p1_ack}, 32'h0);
        if (sb.size() == 0) begin
          check_output("unexpected_ack", {31'h0, rr_if.p1_ack}, 32'hFFFFFFFF);
        end else begin
          e = sb.pop_front();
          check_output("ack_port", {31'h0, rr_if.p1_ack}, {31'h0, e.port});
          check_output("ack_rdata", rr_if.p1_ack ? rr_if.p1_rdata : rr_if.p0_rdata, e.rdata);
        end
      end
      check_output("we_back_to_back", {31'h0, prev_we & rr_if.ram_we}, 32'h0);
      if (!rr_if.busy) begin
        check_output("idle_ram_quiet", {30'h0, rr_if.ram_we, rr_if.ram_re}, 32'h0);
      end
      prev_we <= rr_if.ram_we;
    end
  end

  initial begin
    int acks, first, last, idle, p0_acks, p1_acks, lat;
    logic [3:0] seq;
    exp_t e;

    reset = 1'b1; ram_init = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    fp_if.p0_req = 1'b0; fp_if.p0_we = 1'b0; fp_if.p0_be = 4'h0; fp_if.p0_addr = 14'h0; fp_if.p0_wdata = 32'h0;
    fp_if.p1_req = 1'b0; fp_if.p1_we = 1'b0; fp_if.p1_be = 4'h0; fp_if.p1_addr = 14'h0; fp_if.p1_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("[TB] reset state");
    check_output("rst_p0_ack", {31'h0, rr_if.p0_ack}, 32'h0);
    check_output("rst_p1_ack", {31'h0, rr_if.p1_ack}, 32'h0);
    check_output("rst_p0_rdata", rr_if.p0_rdata, 32'h0);
    check_output("rst_p1_rdata", rr_if.p1_rdata, 32'h0);
    check_output("rst_busy", {31'h0, rr_if.busy}, 32'h0);
    check_output("rst_ram_we", {31'h0, rr_if.ram_we}, 32'h0);
    check_output("rst_ram_re", {31'h0, rr_if.ram_re}, 32'h0);
    check_output("rst_ram_addr", {18'h0, rr_if.ram_addr}, 32'h0);
    check_output("rst_ram_wdata", rr_if.ram_wdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; ram_init = 1'b0;

    $display("[TB] single-port transactions");
    apply_stimulus(1'b0, 1'b0, 4'h0, 14'h0010, 32'h0,        2, 32'hAABBCCDD, 0, 32'h0);
    apply_stimulus(1'b1, 1'b1, 4'h3, 14'h0010, 32'h00001234, 3, 32'hAABBCCDD, 2, 32'hAABB1234);
    apply_stimulus(1'b0, 1'b1, 4'h0, 14'h0020, 32'h12345678, 2, 32'hC0DE0008, 0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 4'hF, 14'h0020, 32'hDEADBEEF, 2, 32'hC0DE0008, 1, 32'hDEADBEEF);
    apply_stimulus(1'b0, 1'b1, 4'hA, 14'h0030, 32'h11223344, 3, 32'hC0DE000C, 2, 32'h11DE330C);
    apply_stimulus(1'b1, 1'b0, 4'h0, 14'h0022, 32'h0,        2, 32'hDEADBEEF, 0, 32'h0);

    $display("[TB] round-robin tie");
    e.port = 1'b0; e.rdata = 32'hAABB1234; sb.push_back(e);
    e.port = 1'b1; e.rdata = 32'hDEADBEEF; sb.push_back(e);
    e.port = 1'b0; e.rdata = 32'hAABB1234; sb.push_back(e);
    e.port = 1'b1; e.rdata = 32'hDEADBEEF; sb.push_back(e);
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 4'h0, 14'h0010, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 4'h0, 14'h0020, 32'h0);
    acks = 0; first = -1; last = -1; idle = 0; seq = 4'h0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!rr_if.busy && acks > 0) idle++;
      if (rr_if.p0_ack || rr_if.p1_ack) begin
        seq[acks] = rr_if.p1_ack;
        if (acks == 0) first = k;
        last = k;
        acks++;
        if (acks == 4) begin
          set_port(1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
          set_port(1'b1, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
          break;
        end
      end
    end
    check_output("rr_ack_count", acks, 4);
    check_output("rr_order", {28'h0, seq}, 32'hA);
    check_output("rr_span", last - first, 9);
    check_output("rr_idle_gaps", idle, 3);

    $display("[TB] reset during read-modify-write");
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b1, 4'h1, 14'h0040, 32'h000000FF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    @(negedge clk);
    check_output("abort_ram_we", {31'h0, rr_if.ram_we}, 32'h0);
    check_output("abort_acks", {30'h0, rr_if.p1_ack, rr_if.p0_ack}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("abort_idle", {31'h0, rr_if.busy}, 32'h0);
    e.port = 1'b0; e.rdata = 32'hC0DE0010; sb.push_back(e);
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 4'h0, 14'h0040, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 4'h0, 14'h0010, 32'h0);
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rr_if.p0_ack || rr_if.p1_ack) begin
        lat = k;
        check_output("post_reset_winner", {31'h0, rr_if.p1_ack}, 32'h0);
        set_port(1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        break;
      end
    end
    check_output("post_reset_latency", lat, 2);

    $display("[TB] fixed priority");
    @(posedge clk); #1;
    fp_if.p0_addr = 14'h0104; fp_if.p1_addr = 14'h0208;
    fp_if.p0_req = 1'b1; fp_if.p1_req = 1'b1;
    p0_acks = 0; p1_acks = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fp_if.p1_ack) p1_acks++;
      if (fp_if.p0_ack) begin
        p0_acks++;
        check_output("fp_p0_rdata", fp_if.p0_rdata, 32'h5A5A0104);
        if (p0_acks == 4) begin
          fp_if.p0_req = 1'b0;
          break;
        end
      end
    end
    check_output("fp_p0_acks", p0_acks, 4);
    check_output("fp_p1_starved", p1_acks, 0);
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (fp_if.p1_ack) begin
        lat = k;
        check_output("fp_p1_rdata", fp_if.p1_rdata, 32'h5A5A0208);
        fp_if.p1_req = 1'b0;
        break;
      end
    end
    check_output("fp_p1_latency", lat, 2);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check_output("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
